// File: rtl/clock_phase_gen.sv
// Multi-channel registered clock generator: each channel divides the master
// clock by 2*(div+1), and new settings take effect only at a period boundary.
module clock_phase_gen #(
  parameter int                NUM_CH  = 4,
  parameter int                CNT_W   = 4,
  parameter int                RST_DIV = 0,
  parameter logic [NUM_CH-1:0] RST_EN  = '1,
  parameter logic [NUM_CH-1:0] RST_INV = '0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_cfg_we,
  input  logic [3:0]        i_cfg_ch,
  input  logic [CNT_W-1:0]  i_cfg_div,
  input  logic              i_cfg_inv,
  input  logic              i_cfg_en,
  input  logic              i_sync_all,
  output logic [NUM_CH-1:0] o_clk_out,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_cfg_pending
);

  typedef struct packed {
    logic [CNT_W-1:0] div;
    logic             inv;
    logic             en;
  } cfg_t;

  localparam logic [CNT_W-1:0] LP_RST_DIV = CNT_W'(RST_DIV);

  cfg_t w_cfg_in;
  assign w_cfg_in = '{div: i_cfg_div, inv: i_cfg_inv, en: i_cfg_en};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam cfg_t LP_RST_CFG = '{div: LP_RST_DIV, inv: RST_INV[g], en: RST_EN[g]};

    cfg_t             r_act, r_shd, w_act_nxt, w_shd_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_ph, w_ph_nxt;
    logic             r_pend, w_pend_nxt;
    logic             r_clk, r_tick;
    logic             w_wr, w_boundary, w_apply;

    // Writes to channel numbers at or above NUM_CH match no channel.
    assign w_wr       = i_cfg_we && (i_cfg_ch == 4'(g));
    assign w_boundary = r_act.en && r_ph && (r_cnt == r_act.div);
    assign w_apply    = r_pend && (w_boundary || !r_act.en);

    always_comb begin
      // NOTE: every next-state signal gets a default first so no path can infer a latch.
      w_act_nxt  = r_act;
      w_shd_nxt  = r_shd;
      w_pend_nxt = r_pend;
      w_cnt_nxt  = r_cnt;
      w_ph_nxt   = r_ph;
      if (i_sync_all) begin
        // A write in the sync cycle reaches the shadow first and is applied by this sync.
        if (w_wr) begin
          w_act_nxt = w_cfg_in;
          w_shd_nxt = w_cfg_in;
        end else if (r_pend) begin
          w_act_nxt = r_shd;
        end
        w_pend_nxt = 1'b0;
        w_cnt_nxt  = '0;
        w_ph_nxt   = 1'b0;
      end else begin
        if (w_apply) begin
          w_act_nxt  = r_shd;
          w_pend_nxt = 1'b0;
          w_cnt_nxt  = '0;
          w_ph_nxt   = 1'b0;
        end else if (r_act.en) begin
          if (r_cnt == r_act.div) begin
            w_cnt_nxt = '0;
            w_ph_nxt  = ~r_ph;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = '0;
          w_ph_nxt  = 1'b0;
        end
        // A write on the apply cycle becomes the next pending config.
        if (w_wr) begin
          w_shd_nxt  = w_cfg_in;
          w_pend_nxt = 1'b1;
        end
      end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        r_act  <= LP_RST_CFG;
        r_shd  <= LP_RST_CFG;
        r_cnt  <= '0;
        r_ph   <= 1'b0;
        r_pend <= 1'b0;
        r_clk  <= RST_INV[g];
        r_tick <= 1'b0;
      end else begin
        r_act  <= w_act_nxt;
        r_shd  <= w_shd_nxt;
        r_cnt  <= w_cnt_nxt;
        r_ph   <= w_ph_nxt;
        r_pend <= w_pend_nxt;
        // Output level is registered directly so the XOR never glitches onto the clock net.
        r_clk  <= w_ph_nxt ^ w_act_nxt.inv;
        r_tick <= w_ph_nxt & ~r_ph;
      end
    end

    assign o_clk_out[g]     = r_clk;
    assign o_tick[g]        = r_tick;
    assign o_cfg_pending[g] = r_pend;
  end

endmodule

// File: tb/tb_clock_phase_gen.sv
// Scoreboard bench for clock_phase_gen: stimulus queues hand-computed
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_clock_phase_gen;

  logic       clock, reset;
  logic       cfg_we, cfg_inv, cfg_en, sync_all;
  logic [3:0] cfg_ch, cfg_div;
  logic [3:0] clk_out, tick, cfg_pending;

  clock_phase_gen #(
    .NUM_CH (4),
    .CNT_W  (4),
    .RST_DIV(0),
    .RST_EN (4'b1111),
    .RST_INV(4'b0010)
  ) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_cfg_we     (cfg_we),
    .i_cfg_ch     (cfg_ch),
    .i_cfg_div    (cfg_div),
    .i_cfg_inv    (cfg_inv),
    .i_cfg_en     (cfg_en),
    .i_sync_all   (sync_all),
    .o_clk_out    (clk_out),
    .o_tick       (tick),
    .o_cfg_pending(cfg_pending)
  );

  typedef struct {
    int         cyc;
    logic [3:0] clk;
    logic [3:0] tk;
    logic [3:0] pd;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   base   = 0;
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Monitor: compare every queued expectation that falls due on this cycle.
  always @(negedge clock) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        if (clk_out !== sb[i].clk || tick !== sb[i].tk || cfg_pending !== sb[i].pd) begin
          errors++;
          $display("FAIL %s cyc=%0d clk_out=%b want %b tick=%b want %b pending=%b want %b",
                   sb[i].name, cyc, clk_out, sb[i].clk, tick, sb[i].tk, cfg_pending, sb[i].pd);
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale expectation for cyc=%0d seen at cyc=%0d", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push_abs(input int at, input logic [3:0] c, input logic [3:0] t,
                          input logic [3:0] p, input string n);
    exp_t e;
    e.cyc = at; e.clk = c; e.tk = t; e.pd = p; e.name = n;
    sb.push_back(e);
  endtask

  task automatic exp_k(input int k, input logic [3:0] c, input logic [3:0] t,
                       input logic [3:0] p, input string n);
    push_abs(base + k, c, t, p, n);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic idle();
    cfg_we = 1'b0; cfg_ch = 4'd0; cfg_div = 4'd0; cfg_inv = 1'b0; cfg_en = 1'b0;
  endtask

  task automatic cfg(input logic [3:0] ch, input logic [3:0] d, input logic inv, input logic en);
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = d; cfg_inv = inv; cfg_en = en;
  endtask

  // Ends on the release negedge; base is then the k=0 reference cycle.
  task automatic do_reset();
    step();
    #2;
    reset = 1'b1;
    idle();
    sync_all = 1'b0;
    push_abs(cyc + 1, 4'b0010, 4'b0000, 4'b0000, "reset_hold");
    step();
    step();
    reset = 1'b0;
    base = cyc;
  endtask

  initial begin
    reset = 1'b1;
    sync_all = 1'b0;
    idle();

    // Reset state and clock/2 on all channels, ch1 inverted.
    do_reset();
    exp_k(1, 4'b1101, 4'b1111, 4'b0000, "rst_k1");
    exp_k(2, 4'b0010, 4'b0000, 4'b0000, "rst_k2");
    exp_k(3, 4'b1101, 4'b1111, 4'b0000, "rst_k3");
    exp_k(4, 4'b0010, 4'b0000, 4'b0000, "rst_k4");
    repeat (4) step();

    // ch2 to D=3 mid-period: short pending, then 8-cycle period high for 4.
    do_reset();
    exp_k(3,  4'b1101, 4'b1111, 4'b0100, "ch2_pend");
    exp_k(4,  4'b0010, 4'b0000, 4'b0000, "ch2_apply");
    exp_k(5,  4'b1001, 4'b1011, 4'b0000, "ch2_low5");
    exp_k(7,  4'b1001, 4'b1011, 4'b0000, "ch2_low7");
    exp_k(8,  4'b0110, 4'b0100, 4'b0000, "ch2_rise8");
    exp_k(11, 4'b1101, 4'b1011, 4'b0000, "ch2_high11");
    exp_k(12, 4'b0010, 4'b0000, 4'b0000, "ch2_fall12");
    exp_k(15, 4'b1001, 4'b1011, 4'b0000, "ch2_low15");
    exp_k(16, 4'b0110, 4'b0100, 4'b0000, "ch2_rise16");
    step(); step();
    cfg(4'd2, 4'd3, 1'b0, 1'b1);
    step();
    idle();
    repeat (13) step();

    // Disable ch0 with inv=1, then re-enable at D=1.
    do_reset();
    exp_k(1,  4'b1101, 4'b1111, 4'b0001, "dis_pend");
    exp_k(2,  4'b0011, 4'b0000, 4'b0000, "dis_idle2");
    exp_k(3,  4'b1101, 4'b1110, 4'b0000, "dis_idle3");
    exp_k(5,  4'b1101, 4'b1110, 4'b0000, "dis_idle5");
    exp_k(6,  4'b0011, 4'b0000, 4'b0001, "reen_pend");
    exp_k(7,  4'b1101, 4'b1110, 4'b0000, "reen_apply");
    exp_k(8,  4'b0011, 4'b0000, 4'b0000, "reen_wait");
    exp_k(9,  4'b1100, 4'b1111, 4'b0000, "reen_tick9");
    exp_k(10, 4'b0010, 4'b0000, 4'b0000, "reen_k10");
    exp_k(11, 4'b1101, 4'b1110, 4'b0000, "reen_k11");
    exp_k(13, 4'b1100, 4'b1111, 4'b0000, "reen_tick13");
    cfg(4'd0, 4'd0, 1'b1, 1'b0);
    step();
    idle();
    repeat (4) step();
    cfg(4'd0, 4'd1, 1'b1, 1'b1);
    step();
    idle();
    repeat (7) step();

    // ch0 D=1, ch1 D=2, then sync_all realigns; pattern repeats after 12.
    do_reset();
    exp_k(1,  4'b1101, 4'b1111, 4'b0001, "pre_pend0");
    exp_k(2,  4'b0010, 4'b0000, 4'b0010, "pre_pend1");
    exp_k(7,  4'b0010, 4'b0000, 4'b0000, "sync_zero");
    exp_k(9,  4'b0011, 4'b0001, 4'b0000, "sync_j2");
    exp_k(10, 4'b1101, 4'b1110, 4'b0000, "sync_j3");
    exp_k(19, 4'b0010, 4'b0000, 4'b0000, "sync_j12");
    exp_k(21, 4'b0011, 4'b0001, 4'b0000, "sync_j14");
    exp_k(22, 4'b1101, 4'b1110, 4'b0000, "sync_j15");
    cfg(4'd0, 4'd1, 1'b0, 1'b1);
    step();
    cfg(4'd1, 4'd2, 1'b1, 1'b1);
    step();
    idle();
    repeat (4) step();
    sync_all = 1'b1;
    step();
    sync_all = 1'b0;
    repeat (15) step();

    // Out-of-range channel ignored; back-to-back writes keep only the last.
    do_reset();
    exp_k(1,  4'b1101, 4'b1111, 4'b0000, "bad_ch");
    exp_k(2,  4'b0010, 4'b0000, 4'b1000, "b2b_pend1");
    exp_k(3,  4'b1101, 4'b1111, 4'b1000, "b2b_pend2");
    exp_k(4,  4'b0010, 4'b0000, 4'b0000, "b2b_apply");
    exp_k(6,  4'b0010, 4'b0000, 4'b0000, "b2b_k6");
    exp_k(7,  4'b1101, 4'b1111, 4'b0000, "b2b_rise7");
    exp_k(9,  4'b1101, 4'b0111, 4'b0000, "b2b_k9");
    exp_k(10, 4'b0010, 4'b0000, 4'b0000, "b2b_fall10");
    exp_k(13, 4'b1101, 4'b1111, 4'b0000, "b2b_rise13");
    cfg(4'd9, 4'd7, 1'b1, 1'b0);
    step();
    cfg(4'd3, 4'd5, 1'b0, 1'b1);
    step();
    cfg(4'd3, 4'd2, 1'b0, 1'b1);
    step();
    idle();
    repeat (10) step();

    // Reset while ch1 is pending discards the write.
    do_reset();
    exp_k(1, 4'b1101, 4'b1111, 4'b0010, "ch1_pend");
    exp_k(2, 4'b0010, 4'b0000, 4'b0000, "rst_mid_pend");
    cfg(4'd1, 4'd4, 1'b0, 1'b1);
    step();
    idle();
    #2;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    base = cyc;
    exp_k(1, 4'b1101, 4'b1111, 4'b0000, "ch1_resume1");
    exp_k(2, 4'b0010, 4'b0000, 4'b0000, "ch1_resume2");
    repeat (3) step();

    // sync_all and cfg_we in the same cycle: write applied by the sync.
    do_reset();
    exp_k(3, 4'b1010, 4'b0000, 4'b0000, "syncwr_j0");
    exp_k(4, 4'b1101, 4'b0111, 4'b0000, "syncwr_j1");
    exp_k(5, 4'b0010, 4'b1000, 4'b0000, "syncwr_j2");
    exp_k(6, 4'b0101, 4'b0111, 4'b0000, "syncwr_j3");
    step(); step();
    cfg(4'd3, 4'd1, 1'b1, 1'b1);
    sync_all = 1'b1;
    step();
    idle();
    sync_all = 1'b0;
    repeat (3) step();

    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations never compared, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
